// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel push-button debouncer.
package multi_debouncer_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, stability and repeat counters,
// and a four-state FSM producing a clean level plus registered pulses.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int SW   = cnt_width(STABLE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_width(RMAX);

    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [RW-1:0] DELAY_C    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD_C   = RW'(REPEAT_PERIOD);

    logic [1:0]    sync_q, sync_d;
    db_state_e     state_q, state_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;   // 0: waiting initial delay, 1: periodic
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;

    logic          s;
    logic [RW-1:0] rep_target;
    logic          rep_fire;

    assign s          = sync_q[1];
    assign rep_target = rep_phase_q ? PERIOD_C : DELAY_C;
    // The repeat counter stops one short of its target and restarts, so it never wraps.
    assign rep_fire   = (REPEAT_EN != 0) && (state_q == HELD) &&
                        ((rep_cnt_q + RW'(1)) >= rep_target);

    // State register: synchroniser, FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            stab_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    // Next-state logic: synchroniser shift, FSM transitions and counter updates.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        sync_d      = {sync_q[0], btn};
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;

        case (state_q)
            IDLE: begin
                stab_cnt_d = '0;
                if (s) begin
                    state_d    = PRESS_WAIT;
                    stab_cnt_d = SW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d    = IDLE;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q >= STABLE_MAX) begin
                    state_d     = HELD;
                    stab_cnt_d  = '0;
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end
            HELD: begin
                stab_cnt_d = '0;
                if (!s) begin
                    state_d    = RELEASE_WAIT;
                    stab_cnt_d = SW'(1);
                end
                if (REPEAT_EN != 0) begin
                    if (rep_fire) begin
                        rep_cnt_d   = '0;
                        rep_phase_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // Repeat counter is left untouched here so it resumes on return to HELD.
                if (s) begin
                    state_d    = HELD;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q >= STABLE_MAX) begin
                    state_d    = IDLE;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                stab_cnt_d = '0;
            end
        endcase
    end

    // Output logic: next values of the registered level and pulses.
    always_comb begin
        level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
        press_d   = (state_q == PRESS_WAIT)   && (state_d == HELD);
        release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
        repeat_d  = rep_fire;
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: one independent debounce_channel per button.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    // Parameter sanity: counters and latencies assume these ranges.
    param_range_a : assert property (@(posedge clk)
        (CHANNELS >= 1) && (STABLE_CYCLES >= 2) &&
        ((REPEAT_EN == 0) || (REPEAT_EN == 1)) &&
        (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .btn         (btn[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: press/release latency, bounce rejection,
// auto-repeat timing, mid-count reset and simultaneous channels.
module tb_multi_debouncer;

    localparam int CH  = 4;
    localparam int SC  = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = SC + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] btn = '0;
    logic [CH-1:0] lvl, prs, rel, rpt;
    logic [CH-1:0] nr_lvl, nr_prs, nr_rel, nr_rpt;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rpt)
    );

    multi_debouncer #(
        .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(nr_lvl), .btn_press(nr_prs), .btn_release(nr_rel), .btn_repeat(nr_rpt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int press_cnt[CH], press_cyc[CH], rel_cnt[CH], rel_cyc[CH];
    int rpt_cnt[CH], rise_cyc[CH], fall_cyc[CH], fall_cnt[CH];
    int rpt_cyc0[8];
    int nr_press_cyc0, nr_rel_cyc0, nr_press_cnt0;
    int nr_rpt_total = 0;
    int overlap_bad  = 0;
    bit press_all, rel_all;
    logic [CH-1:0] prev_lvl = '0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < CH; i++) begin
            press_cnt[i] = 0; press_cyc[i] = 0; rel_cnt[i] = 0; rel_cyc[i] = 0;
            rpt_cnt[i] = 0; rise_cyc[i] = 0; fall_cyc[i] = 0; fall_cnt[i] = 0;
        end
        for (int i = 0; i < 8; i++) rpt_cyc0[i] = 0;
        nr_press_cyc0 = 0; nr_rel_cyc0 = 0; nr_press_cnt0 = 0;
        press_all = 1'b0; rel_all = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge monitor: numbers each rising edge and logs output events shortly after it.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < CH; i++) begin
                if (prs[i]) begin press_cnt[i]++; press_cyc[i] = cyc; end
                if (rel[i]) begin rel_cnt[i]++; rel_cyc[i] = cyc; end
                if (rpt[i]) begin
                    if (i == 0 && rpt_cnt[0] < 8) rpt_cyc0[rpt_cnt[0]] = cyc;
                    rpt_cnt[i]++;
                end
                if (lvl[i] && !prev_lvl[i]) rise_cyc[i] = cyc;
                if (!lvl[i] && prev_lvl[i]) begin fall_cyc[i] = cyc; fall_cnt[i]++; end
                if ((prs[i] && rel[i]) || (prs[i] && rpt[i])) overlap_bad++;
            end
            if (prs == 4'hF) press_all = 1'b1;
            if (rel == 4'hF) rel_all = 1'b1;
            if (nr_prs[0]) begin nr_press_cnt0++; nr_press_cyc0 = cyc; end
            if (nr_rel[0]) nr_rel_cyc0 = cyc;
            nr_rpt_total += $countones(nr_rpt);
            prev_lvl = lvl;
        end
    end

    initial begin
        int e, e_rel;
        bit bounce [9];
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        clear_stats();
        idle(3);
        check("reset_level",      int'(lvl),    0);
        check("reset_press",      int'(prs),    0);
        check("reset_release",    int'(rel),    0);
        check("reset_repeat",     int'(rpt),    0);
        check("reset_nr_level",   int'(nr_lvl), 0);
        check("reset_nr_press",   int'(nr_prs), 0);
        check("reset_nr_release", int'(nr_rel), 0);
        check("reset_nr_repeat",  int'(nr_rpt), 0);
        rst = 1'b0;
        idle(2);

        // Clean press on ch0, held long enough for four repeats, then clean release.
        clear_stats();
        btn[0] = 1'b1; e = cyc + 1;
        idle(46);
        btn[0] = 1'b0; e_rel = cyc + 1;
        idle(15);
        check("s1_press_cnt",  press_cnt[0], 1);
        check("s1_press_cyc",  press_cyc[0], e + LAT);
        check("s1_level_rise", rise_cyc[0],  e + LAT);
        check("s1_rpt_cnt",    rpt_cnt[0],   4);
        for (int k = 0; k < 4; k++)
            check($sformatf("s1_rpt%0d_cyc", k), rpt_cyc0[k], e + LAT + RD + k * RP);
        check("s1_rel_cnt",    rel_cnt[0],   1);
        check("s1_rel_cyc",    rel_cyc[0],   e_rel + LAT);
        check("s1_level_fall", fall_cyc[0],  e_rel + LAT);
        check("s1_other_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        check("s1_other_rpt",   rpt_cnt[1] + rpt_cnt[2] + rpt_cnt[3], 0);
        check("s1_nr_press_cnt", nr_press_cnt0, 1);
        check("s1_nr_press_cyc", nr_press_cyc0, e + LAT);
        check("s1_nr_rel_cyc",   nr_rel_cyc0,   e_rel + LAT);
        check("s1_nr_rpt_total", nr_rpt_total,  0);

        // Bouncy press on ch1: only the final steady high is accepted.
        clear_stats();
        for (int i = 0; i < 9; i++) begin
            btn[1] = bounce[i];
            idle(1);
        end
        btn[1] = 1'b1; e = cyc + 1;
        idle(15);
        check("s2_press_cnt",  press_cnt[1], 1);
        check("s2_press_cyc",  press_cyc[1], e + LAT);
        check("s2_level_rise", rise_cyc[1],  e + LAT);
        btn[1] = 1'b0; e_rel = cyc + 1;
        idle(12);
        check("s2_rel_cyc",    rel_cyc[1],   e_rel + LAT);

        // Bouncy release on ch2: glitch high during release wait is ignored.
        clear_stats();
        btn[2] = 1'b1; e = cyc + 1;
        idle(12);
        check("s3_press_cyc", press_cyc[2], e + LAT);
        btn[2] = 1'b0; idle(4);
        btn[2] = 1'b1; idle(1);
        btn[2] = 1'b0; e_rel = cyc + 1;
        idle(14);
        check("s3_press_cnt", press_cnt[2], 1);
        check("s3_rel_cnt",   rel_cnt[2],   1);
        check("s3_rel_cyc",   rel_cyc[2],   e_rel + LAT);
        check("s3_fall_cyc",  fall_cyc[2],  e_rel + LAT);
        check("s3_fall_cnt",  fall_cnt[2],  1);
        check("s3_rpt_cnt",   rpt_cnt[2],   0);

        // Reset while ch3 is at press-wait count 5; button stays high.
        clear_stats();
        btn[3] = 1'b1; e = cyc + 1;
        idle(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("s4_rst_level",   int'(lvl), 0);
        check("s4_rst_press",   int'(prs), 0);
        check("s4_rst_release", int'(rel), 0);
        check("s4_rst_repeat",  int'(rpt), 0);
        idle(14);
        check("s4_press_cnt", press_cnt[3], 1);
        check("s4_press_cyc", press_cyc[3], e + 8 + LAT);
        btn[3] = 1'b0;
        idle(12);

        // All channels pressed and released on the same edge.
        clear_stats();
        btn = 4'hF; e = cyc + 1;
        idle(12);
        check("s5_press_all", int'(press_all), 1);
        for (int i = 0; i < CH; i++)
            check($sformatf("s5_press_cyc%0d", i), press_cyc[i], e + LAT);
        btn = 4'h0; e_rel = cyc + 1;
        idle(12);
        check("s5_rel_all", int'(rel_all), 1);
        for (int i = 0; i < CH; i++)
            check($sformatf("s5_rel_cyc%0d", i), rel_cyc[i], e_rel + LAT);

        check("overlap_pulses", overlap_bad,  0);
        check("nr_rpt_final",   nr_rpt_total, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
